seq_pattern_tx: RTL

Serial pattern transmitter, the source side of the single-bit serial line that the team's sequence-detector FSMs consume. It captures a WIDTH-bit pattern on a start request and shifts it out MSB-first on `out`, one bit per clock. The pattern is repeated a programmable number of times, with an optional idle gap between repetitions. Used to drive detector blocks in-system and on benches with known bit streams, e.g. 1011.

---
 rtl/seq_pattern_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
// Serial pattern source for the sequence-detector blocks. A WIDTH-bit pattern
// is captured on start and shifted out MSB-first on out, one bit per clock,
// repeated repeat_cnt times with GAP idle cycles between repetitions.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   start       transmit request, sampled in IDLE only
//   pattern     bits to send, MSB first
//   repeat_cnt  number of repetitions, 0 ignores the request
//   abort       synchronous cancel while SHIFT or GAP
//   out         registered serial data
//   out_valid   high while out carries a pattern bit
//   busy        high through every SHIFT and GAP cycle
//   done        one-cycle pulse after the last bit of the last repetition
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start with a non-zero repeat count
// S_SHIFT | driving shift_reg[bit_idx] on out
// S_GAP   | idle gap between repetitions, busy held high
// S_DONE  | single-cycle done pulse, start ignored

module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_TOP = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shift_reg, shift_nx;
    logic [IDX_W-1:0] bit_idx, idx_nx;
    logic [CNT_W-1:0] reps_left, reps_nx;
    logic [GAP_W-1:0] gap_cnt, gap_nx;
    logic             out_nx, valid_nx, busy_nx, done_nx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            reps_left <= '0;
            gap_cnt   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_reg <= shift_nx;
            bit_idx   <= idx_nx;
            reps_left <= reps_nx;
            gap_cnt   <= gap_nx;
            out       <= out_nx;
            out_valid <= valid_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    // Outputs are computed for the state being entered, so the registered
    // outputs always describe the current state without a one-cycle lag.
    always_comb begin
        state_nx = state;
        shift_nx = shift_reg;
        idx_nx   = bit_idx;
        reps_nx  = reps_left;
        gap_nx   = gap_cnt;
        out_nx   = 1'b0;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && (repeat_cnt != '0)) begin
                    shift_nx = pattern;
                    reps_nx  = repeat_cnt;
                    idx_nx   = IDX_TOP;
                    state_nx = S_SHIFT;
                    out_nx   = pattern[WIDTH-1];
                    valid_nx = 1'b1;
                    busy_nx  = 1'b1;
                end
            end

            S_SHIFT: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (bit_idx != '0) begin
                    idx_nx   = bit_idx - IDX_W'(1);
                    out_nx   = shift_reg[idx_nx];
                    valid_nx = 1'b1;
                    busy_nx  = 1'b1;
                end else if (reps_left > CNT_W'(1)) begin
                    reps_nx = reps_left - CNT_W'(1);
                    idx_nx  = IDX_TOP;
                    busy_nx = 1'b1;
                    if (GAP > 0) begin
                        state_nx = S_GAP;
                        gap_nx   = GAP_TOP;
                    end else begin
                        out_nx   = shift_reg[WIDTH-1];
                        valid_nx = 1'b1;
                    end
                end else begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                end
            end

            S_GAP: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (gap_cnt == '0) begin
                    state_nx = S_SHIFT;
                    out_nx   = shift_reg[WIDTH-1];
                    valid_nx = 1'b1;
                    busy_nx  = 1'b1;
                end else begin
                    gap_nx  = gap_cnt - GAP_W'(1);
                    busy_nx = 1'b1;
                end
            end

            S_DONE: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
